ac_motor_vf_sequencer: RTL and testbench



---
 rtl/ac_motor_pkg.sv | 29 ++
 rtl/ac_motor_ramp_tick.sv | 36 +++
 rtl/ac_motor_vf_sequencer.sv | 140 ++++++++++++++
 tb/tb_ac_motor_vf_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_motor_pkg.sv
// Shared types, defaults and the V/f law for the space-vector run-control sequencer.
package ac_motor_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_RUN   = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    localparam int unsigned DEFAULT_WIDTH    = 12;
    localparam int unsigned DEFAULT_U_BOOST  = 256;
    localparam int unsigned DEFAULT_VF_GAIN  = 16;
    localparam int unsigned DEFAULT_VF_SHIFT = 4;
    localparam int unsigned DEFAULT_U_MAX    = 4095;

    // Evaluated at 32 bits, which holds the WIDTH+8 bit product for WIDTH up to 23.
    function automatic int unsigned vf_law(input int unsigned freq,
                                           input int unsigned boost,
                                           input int unsigned gain,
                                           input int unsigned shift,
                                           input int unsigned umax);
        int unsigned volts;
        volts = boost + ((freq * gain) >> shift);
        return (volts > umax) ? umax : volts;
    endfunction

endpackage

// File: rtl/ac_motor_ramp_tick.sv
// Ramp-rate prescaler: pulses tick once every RAMP_DIV cycles while run is high.
module ac_motor_ramp_tick #(
    parameter int unsigned RAMP_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = run && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ac_motor_vf_sequencer.sv
// Start/stop/fault sequencer driving frequency and V/f-scaled u_str into the SVPWM chain.
module ac_motor_vf_sequencer
    import ac_motor_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned RAMP_DIV = 1000,
    parameter int unsigned STEP     = 1,
    parameter int unsigned U_BOOST  = DEFAULT_U_BOOST,
    parameter int unsigned VF_GAIN  = DEFAULT_VF_GAIN,
    parameter int unsigned VF_SHIFT = DEFAULT_VF_SHIFT,
    parameter int unsigned U_MAX    = DEFAULT_U_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             fault,
    input  logic             fault_clr,
    input  logic [WIDTH-1:0] f_target,
    output logic [WIDTH-1:0] frequency,
    output logic [WIDTH-1:0] u_str,
    output logic             pwm_en,
    output logic             at_speed,
    output logic [2:0]       state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] freq_q, freq_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic             pwm_q, pwm_d;
    logic             at_speed_q, at_speed_d;
    logic             armed_q, armed_d;
    logic             tick, ramp_run, ramp_clr;

    logic [WIDTH:0]   freq_x, target_x, step_x, up_x, down_x, floor_x;
    logic [WIDTH-1:0] toward_target, toward_zero;

    // One extra bit of headroom so stepping never wraps before clamping.
    assign freq_x   = {1'b0, freq_q};
    assign target_x = {1'b0, f_target};
    assign step_x   = (WIDTH+1)'(STEP);
    assign up_x     = freq_x + step_x;
    assign down_x   = freq_x - step_x;
    assign floor_x  = target_x + step_x;

    assign toward_target = (freq_x < target_x)
                         ? ((up_x >= target_x) ? f_target : up_x[WIDTH-1:0])
                         : ((freq_x <= floor_x) ? f_target : down_x[WIDTH-1:0]);
    assign toward_zero   = (freq_x <= step_x) ? '0 : down_x[WIDTH-1:0];

    assign ramp_run = (state_q == S_RAMP) || (state_q == S_STOP);
    assign ramp_clr = (state_d != state_q);

    ac_motor_ramp_tick #(
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ramp_clr),
        .run   (ramp_run),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        armed_d = armed_q;
        if (fault) begin
            state_d = S_FAULT;
            freq_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    freq_d = '0;
                    // A start held through a fault must drop once before it counts again.
                    if (!start) armed_d = 1'b1;
                    if (start && !stop && armed_q && (f_target != '0)) state_d = S_RAMP;
                end
                S_RAMP: begin
                    if (stop) begin
                        state_d = S_STOP;
                    end else if (tick) begin
                        freq_d = toward_target;
                        if (toward_target == f_target) state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop || (f_target == '0)) state_d = S_STOP;
                    else if (f_target != freq_q)  state_d = S_RAMP;
                end
                S_STOP: begin
                    if (tick) begin
                        freq_d = toward_zero;
                        if (toward_zero == '0) state_d = S_IDLE;
                    end
                end
                S_FAULT: begin
                    freq_d = '0;
                    if (fault_clr) begin
                        state_d = S_IDLE;
                        armed_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    freq_d  = '0;
                end
            endcase
        end

        pwm_d      = (state_d == S_RAMP) || (state_d == S_RUN) || (state_d == S_STOP);
        at_speed_d = (state_d == S_RUN);
        u_d        = pwm_d ? WIDTH'(vf_law(32'(freq_d), U_BOOST, VF_GAIN, VF_SHIFT, U_MAX)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            freq_q     <= '0;
            u_q        <= '0;
            pwm_q      <= 1'b0;
            at_speed_q <= 1'b0;
            armed_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            freq_q     <= freq_d;
            u_q        <= u_d;
            pwm_q      <= pwm_d;
            at_speed_q <= at_speed_d;
            armed_q    <= armed_d;
        end
    end

    assign frequency = freq_q;
    assign u_str     = u_q;
    assign pwm_en    = pwm_q;
    assign at_speed  = at_speed_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ac_motor_vf_sequencer.sv
// Self-checking bench: scenario tasks plus randomized traffic against a behavioural model.
module tb_ac_motor_vf_sequencer;
    import ac_motor_pkg::*;

    localparam int W        = 12;
    localparam int RAMP_DIV = 4;
    localparam int STEP     = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, stop, fault, fault_clr;
    logic [W-1:0]  f_target;
    logic [W-1:0]  frequency, u_str;
    logic          pwm_en, at_speed;
    logic [2:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: state code, frequency, edges spent in current state, re-arm flag.
    int            m_state, m_freq, m_since;
    bit            m_armed;
    logic [28:0]   exp_vec;
    logic [28:0]   obs_vec;

    assign obs_vec = {state, frequency, u_str, pwm_en, at_speed};

    ac_motor_vf_sequencer #(
        .WIDTH(W), .RAMP_DIV(RAMP_DIV), .STEP(STEP),
        .U_BOOST(DEFAULT_U_BOOST), .VF_GAIN(DEFAULT_VF_GAIN),
        .VF_SHIFT(DEFAULT_VF_SHIFT), .U_MAX(DEFAULT_U_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .fault(fault),
        .fault_clr(fault_clr), .f_target(f_target), .frequency(frequency),
        .u_str(u_str), .pwm_en(pwm_en), .at_speed(at_speed), .state(state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_freq  = 0;
        m_since = 0;
        m_armed = 1'b1;
        exp_vec = '0;
    endtask

    // Applies one clock edge of the run-control rules to the model.
    task automatic model_edge();
        int ns, nf, ft;
        bit tk, pwm;
        ft = int'(f_target);
        tk = (m_state == 1 || m_state == 3) && ((m_since % RAMP_DIV) == RAMP_DIV - 1);
        ns = m_state;
        nf = m_freq;
        if (fault) begin
            ns = 4; nf = 0;
        end else if (m_state == 0) begin
            nf = 0;
            if (start && !stop && m_armed && ft != 0) ns = 1;
            if (!start) m_armed = 1'b1;
        end else if (m_state == 1) begin
            if (stop) ns = 3;
            else if (tk) begin
                if (ft > m_freq) nf = (m_freq + STEP > ft) ? ft : m_freq + STEP;
                else             nf = (m_freq - STEP < ft) ? ft : m_freq - STEP;
                if (nf == ft) ns = 2;
            end
        end else if (m_state == 2) begin
            if (stop || ft == 0) ns = 3;
            else if (ft != m_freq) ns = 1;
        end else if (m_state == 3) begin
            if (tk) begin
                nf = (m_freq - STEP < 0) ? 0 : m_freq - STEP;
                if (nf == 0) ns = 0;
            end
        end else begin
            nf = 0;
            if (fault_clr) begin ns = 0; m_armed = 1'b0; end
        end
        m_since = (ns != m_state) ? 0 : m_since + 1;
        m_state = ns;
        m_freq  = nf;
        pwm     = (ns >= 1 && ns <= 3);
        exp_vec = {3'(ns), 12'(nf),
                   pwm ? 12'(vf_law(nf, DEFAULT_U_BOOST, DEFAULT_VF_GAIN, DEFAULT_VF_SHIFT, DEFAULT_U_MAX)) : 12'd0,
                   pwm, (ns == 2)};
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle_idle(input string name);
        start = 1'b0; stop = 1'b1; fault = 1'b0; fault_clr = 1'b0;
        for (int i = 0; i < 1500 && m_state != 0; i++) begin
            tick_cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("[TB] FAIL %s_settle cyc %0d: got %h expected %h", name, i, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (state !== 3'd0) begin
            n_errors++;
            $display("[TB] FAIL %s_idle_timeout: state got %0d expected 0", name, state);
        end
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0; f_target = '0;
        model_reset();
        #12;
        n_checks++;
        if (obs_vec !== 29'd0) begin
            n_errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", obs_vec);
        end
        rst_n = 1'b1;
        tick_cycle();
        n_checks++;
        if (obs_vec !== exp_vec) begin
            n_errors++;
            $display("[TB] FAIL reset_idle_hold: got %h expected %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_ramp_up();
        start = 1'b1; f_target = 12'd64;
        for (int c = 1; c <= 20; c++) begin
            tick_cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("[TB] FAIL ramp_up cyc %0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c == 1) begin
                n_checks++;
                if (pwm_en !== 1'b1 || u_str !== 12'd256) begin
                    n_errors++;
                    $display("[TB] FAIL ramp_entry: pwm_en/u_str got %b/%0d expected 1/256", pwm_en, u_str);
                end
            end
            if (c % 4 == 1 && c >= 5 && c <= 17) begin
                n_checks++;
                if (frequency !== 12'((c - 1) / 4 * 16)) begin
                    n_errors++;
                    $display("[TB] FAIL ramp_step cyc %0d: frequency got %0d expected %0d", c, frequency, (c - 1) / 4 * 16);
                end
            end
        end
        n_checks++;
        if (state !== 3'd2 || at_speed !== 1'b1 || u_str !== 12'd320) begin
            n_errors++;
            $display("[TB] FAIL ramp_run: state/at_speed/u_str got %0d/%b/%0d expected 2/1/320", state, at_speed, u_str);
        end
    endtask

    task automatic test_stop();
        start = 1'b0; stop = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick_cycle();
            if (c == 1) stop = 1'b0;
            start = (c == 7);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("[TB] FAIL stop cyc %0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c == 13) begin
                n_checks++;
                if (frequency !== 12'd16 || state !== 3'd3) begin
                    n_errors++;
                    $display("[TB] FAIL stop_ramp_down: freq/state got %0d/%0d expected 16/3", frequency, state);
                end
            end
            if (c == 17) begin
                n_checks++;
                if (state !== 3'd0 || pwm_en !== 1'b0 || u_str !== 12'd0) begin
                    n_errors++;
                    $display("[TB] FAIL stop_to_idle: state/pwm/u got %0d/%b/%0d expected 0/0/0", state, pwm_en, u_str);
                end
            end
        end
    endtask

    task automatic test_clamp();
        start = 1'b1; f_target = 12'd40;
        for (int c = 1; c <= 16; c++) begin
            tick_cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("[TB] FAIL clamp cyc %0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (frequency !== 12'd40 || u_str !== 12'd296 || state !== 3'd2) begin
            n_errors++;
            $display("[TB] FAIL clamp_final: freq/u/state got %0d/%0d/%0d expected 40/296/2", frequency, u_str, state);
        end
        settle_idle("clamp");
    endtask

    task automatic test_saturation();
        start = 1'b1; f_target = 12'd4095;
        for (int c = 1; c <= 1100; c++) begin
            tick_cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("[TB] FAIL saturation cyc %0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (frequency >= 12'd3839) begin
                n_checks++;
                if (u_str !== 12'd4095) begin
                    n_errors++;
                    $display("[TB] FAIL u_saturate: u_str got %0d expected 4095 at freq %0d", u_str, frequency);
                end
            end
        end
        n_checks++;
        if (frequency !== 12'd4095 || state !== 3'd2) begin
            n_errors++;
            $display("[TB] FAIL sat_final: freq/state got %0d/%0d expected 4095/2", frequency, state);
        end
        settle_idle("saturation");
    endtask

    task automatic test_fault();
        start = 1'b1; f_target = 12'd64;
        for (int c = 1; c <= 17; c++) tick_cycle();
        fault = 1'b1;
        tick_cycle();
        n_checks++;
        if (state !== 3'd4 || pwm_en !== 1'b0 || frequency !== 12'd0 || u_str !== 12'd0 || at_speed !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL fault_entry: got %h expected state 4 all else 0", obs_vec);
        end
        fault_clr = 1'b1;
        tick_cycle();
        tick_cycle();
        n_checks++;
        if (state !== 3'd4) begin
            n_errors++;
            $display("[TB] FAIL fault_clr_ignored: state got %0d expected 4", state);
        end
        fault = 1'b0;
        tick_cycle();
        fault_clr = 1'b0;
        n_checks++;
        if (obs_vec !== exp_vec || state !== 3'd0) begin
            n_errors++;
            $display("[TB] FAIL fault_exit: got %h expected %h", obs_vec, exp_vec);
        end
        for (int c = 0; c < 4; c++) begin
            tick_cycle();
            n_checks++;
            if (state !== 3'd0) begin
                n_errors++;
                $display("[TB] FAIL held_start_rearm cyc %0d: state got %0d expected 0", c, state);
            end
        end
        start = 1'b0;
        tick_cycle();
        start = 1'b1;
        tick_cycle();
        n_checks++;
        if (state !== 3'd1 || obs_vec !== exp_vec) begin
            n_errors++;
            $display("[TB] FAIL rearm_start: got %h expected %h", obs_vec, exp_vec);
        end
        settle_idle("fault");
    endtask

    task automatic test_reset_midramp();
        start = 1'b1; f_target = 12'd64;
        for (int c = 1; c <= 9; c++) tick_cycle();
        n_checks++;
        if (frequency !== 12'd32) begin
            n_errors++;
            $display("[TB] FAIL midramp_freq: got %0d expected 32", frequency);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec !== 29'd0) begin
            n_errors++;
            $display("[TB] FAIL async_reset: got %h expected 0", obs_vec);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick_cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("[TB] FAIL post_reset cyc %0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (frequency !== 12'd16) begin
            n_errors++;
            $display("[TB] FAIL post_reset_prescale: freq got %0d expected 16", frequency);
        end
        settle_idle("reset_midramp");
    endtask

    task automatic test_random();
        f_target = 12'($urandom_range(0, 200));
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 29) == 0) f_target = 12'($urandom_range(0, 200));
            start     = ($urandom_range(0, 3) != 0);
            stop      = ($urandom_range(0, 24) == 0);
            fault     = ($urandom_range(0, 79) == 0);
            fault_clr = ($urandom_range(0, 3) == 0);
            tick_cycle();
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_errors++;
                $display("[TB] FAIL random cyc %0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
        settle_idle("random");
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_stop();
        test_clamp();
        test_saturation();
        test_fault();
        test_reset_midramp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
